// File: rtl/pipelined_instr_decoder.sv
// Pipelined instruction decoder: register file with write-back bypass,
// pending-write scoreboard for RAW stalls and a registered valid/ready output stage.
module pipelined_instr_decoder #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned IMM_W   = 16,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] opa,
  output logic [DATA_W-1:0] opb,
  output logic [DATA_W-1:0] str_data,
  output logic [DATA_W-1:0] pc_out,
  output logic [REG_AW-1:0] rd_out,
  output logic [1:0]        funtype,
  output logic [1:0]        funcode,
  output logic              sel_wb,
  output logic              sel_memrd,
  output logic              sel_memwr,
  output logic              sel_branch,
  output logic              sel_imm
);

  localparam int unsigned NUM_REGS = 1 << REG_AW;
  localparam int unsigned RD_LO    = 28 - REG_AW;
  localparam int unsigned RA_LO    = 28 - 2 * REG_AW;
  localparam int unsigned RB_LO    = 28 - 3 * REG_AW;

  // Field map must fit in a 32-bit instruction word
  if (4 + 3 * REG_AW + IMM_W > 32) begin : g_cfg_check
    $error("pipelined_instr_decoder: 4+3*REG_AW+IMM_W exceeds 32 bits");
  end

  typedef struct packed {
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] str;
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] rd;
    logic [1:0]        ft;
    logic [1:0]        fc;
    logic              wb;
    logic              memrd;
    logic              memwr;
    logic              branch;
    logic              imm;
  } bundle_t;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  bundle_t             out_q, out_d, dec_b;
  logic                out_valid_q, out_valid_d;

  logic [1:0]        dec_ft, dec_fc;
  logic [REG_AW-1:0] dec_rd, dec_ra, dec_rb;
  logic [DATA_W-1:0] imm_ext, ra_val, rb_val, rd_val;
  logic              dec_wb, dec_memrd, dec_memwr, dec_branch, dec_imm;
  logic              haz_ra, haz_rb, haz_rd, hazard;
  logic              accept, fire, rf_we;

  assign dec_ft  = instr[31:30];
  assign dec_fc  = instr[29:28];
  assign dec_rd  = instr[RD_LO +: REG_AW];
  assign dec_ra  = instr[RA_LO +: REG_AW];
  assign dec_rb  = instr[RB_LO +: REG_AW];
  assign imm_ext = DATA_W'($signed(instr[IMM_W-1:0]));

  // Control selects from funtype/funcode; memory funcode 1x leaves a NOP bundle
  always_comb begin
    dec_wb     = 1'b0;
    dec_memrd  = 1'b0;
    dec_memwr  = 1'b0;
    dec_branch = 1'b0;
    dec_imm    = 1'b0;
    case (dec_ft)
      2'b00: dec_wb = 1'b1;
      2'b01: begin
        dec_wb  = 1'b1;
        dec_imm = 1'b1;
      end
      2'b10: begin
        if (dec_fc == 2'b00) begin
          dec_memrd = 1'b1;
          dec_wb    = 1'b1;
          dec_imm   = 1'b1;
        end else if (dec_fc == 2'b01) begin
          dec_memwr = 1'b1;
          dec_imm   = 1'b1;
        end
      end
      default: begin
        dec_branch = 1'b1;
        dec_imm    = 1'b1;
      end
    endcase
  end

  // Register reads with same-cycle write-back bypass; r0 optionally hardwired
  assign ra_val = (R0_ZERO && dec_ra == '0) ? '0 :
                  (wb_we && wb_rd == dec_ra) ? wb_data : regs_q[dec_ra];
  assign rb_val = (R0_ZERO && dec_rb == '0) ? '0 :
                  (wb_we && wb_rd == dec_rb) ? wb_data : regs_q[dec_rb];
  assign rd_val = (R0_ZERO && dec_rd == '0) ? '0 :
                  (wb_we && wb_rd == dec_rd) ? wb_data : regs_q[dec_rd];

  // A source is blocked by a pending write not landing this cycle, or by the
  // writer still sitting in the output stage
  function automatic logic src_blocked(
    input logic [REG_AW-1:0]   src,
    input logic [NUM_REGS-1:0] busy,
    input logic                wb_en,
    input logic [REG_AW-1:0]   wb_dst,
    input logic                stage_wr,
    input logic [REG_AW-1:0]   stage_rd
  );
    logic is_r0;
    is_r0 = R0_ZERO && (src == '0);
    return !is_r0 && ((busy[src] && !(wb_en && wb_dst == src)) ||
                      (stage_wr && stage_rd == src));
  endfunction

  assign haz_ra = src_blocked(dec_ra, busy_q, wb_we, wb_rd, out_valid_q && out_q.wb, out_q.rd);
  assign haz_rb = src_blocked(dec_rb, busy_q, wb_we, wb_rd, out_valid_q && out_q.wb, out_q.rd);
  assign haz_rd = src_blocked(dec_rd, busy_q, wb_we, wb_rd, out_valid_q && out_q.wb, out_q.rd);

  assign hazard   = in_valid && (haz_ra || (!dec_imm && haz_rb) || (dec_memwr && haz_rd));
  assign in_ready = !hazard && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid_q && out_ready;
  assign rf_we    = wb_we && !(R0_ZERO && wb_rd == '0);

  // Assemble the decoded bundle
  always_comb begin
    dec_b        = '0;
    dec_b.opa    = ra_val;
    dec_b.opb    = dec_imm ? imm_ext : rb_val;
    dec_b.str    = rd_val;
    dec_b.pc     = pc_in;
    dec_b.rd     = dec_rd;
    dec_b.ft     = dec_ft;
    dec_b.fc     = dec_fc;
    dec_b.wb     = dec_wb;
    dec_b.memrd  = dec_memrd;
    dec_b.memwr  = dec_memwr;
    dec_b.branch = dec_branch;
    dec_b.imm    = dec_imm;
  end

  // Output stage next state: flush beats accept beats fire; otherwise hold
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = dec_b;
      out_valid_d = 1'b1;
    end else if (fire) begin
      out_valid_d = 1'b0;
    end
  end

  // Scoreboard next state: write-back clears, a firing writer sets (set wins)
  always_comb begin
    busy_d = busy_q;
    if (wb_we) busy_d[wb_rd] = 1'b0;
    if (fire && !flush && out_q.wb && !(R0_ZERO && out_q.rd == '0)) busy_d[out_q.rd] = 1'b1;
  end

  // Output stage and scoreboard registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Register file write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else if (rf_we) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  assign out_valid  = out_valid_q;
  assign opa        = out_q.opa;
  assign opb        = out_q.opb;
  assign str_data   = out_q.str;
  assign pc_out     = out_q.pc;
  assign rd_out     = out_q.rd;
  assign funtype    = out_q.ft;
  assign funcode    = out_q.fc;
  assign sel_wb     = out_q.wb;
  assign sel_memrd  = out_q.memrd;
  assign sel_memwr  = out_q.memwr;
  assign sel_branch = out_q.branch;
  assign sel_imm    = out_q.imm;

endmodule

// File: doc/pipelined_instr_decoder.md
Name: pipelined_instr_decoder

Overview:
- Parametrised successor of the single-cycle instruction decoder: decodes one instruction per cycle into operands and control selects.
- Contains a register file of 2^REG_AW registers, a write-back bypass, a pending-write scoreboard that stalls dependent instructions, and a registered output stage with valid/ready handshake.
- Sits between fetch and execute. The write-back port comes from the last pipeline stage.

Parameters:
- DATA_W, 32, register, operand and write-back data width.
- REG_AW, 4, register address width; NUM_REGS = 2^REG_AW.
- IMM_W, 16, immediate field width, taken from instr[IMM_W-1:0] and sign-extended to DATA_W.
- R0_ZERO, 1, when 1 register 0 reads as 0, ignores writes and is never marked busy.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction valid from fetch.
- in_ready  out  1  decoder accepts instruction this cycle.
- instr  in  32  instruction word.
- pc_in  in  DATA_W  PC of instr.
- flush  in  1  discard output-stage contents (branch taken).
- wb_we  in  1  write-back enable.
- wb_rd  in  REG_AW  write-back destination.
- wb_data  in  DATA_W  write-back data.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts bundle.
- opa, opb  out  DATA_W  operand A; operand B (rb value or sign-extended immediate).
- str_data  out  DATA_W  store data (value of rd register).
- pc_out  out  DATA_W  registered pc_in.
- rd_out  out  REG_AW  destination register.
- funtype, funcode  out  2 each  instr[31:30], instr[29:28].
- sel_wb, sel_memrd, sel_memwr, sel_branch, sel_imm  out  1 each  control selects.

Behaviour:
- Field map: funtype = [31:30]; funcode = [29:28]; rd = [27:28-REG_AW]; ra = next REG_AW bits; rb = next REG_AW bits; imm = [IMM_W-1:0]. Elaboration error if 4+3*REG_AW+IMM_W > 32.
- Control decode by funtype:
  - 00: ALU reg-reg, sel_wb = 1.
  - 01: ALU reg-imm, sel_wb = 1, sel_imm = 1.
  - 10: memory. funcode 00 is a load (sel_memrd = 1, sel_wb = 1, sel_imm = 1). funcode 01 is a store (sel_memwr = 1, sel_imm = 1). funcode 1x is a NOP bundle.
  - 11: branch, sel_branch = 1, sel_imm = 1.
- Sources used:
  - ra: always.
  - rb: only when sel_imm = 0.
  - rd: read as a source only for stores.
- Register file:
  - Write on the rising edge when wb_we = 1, skipped if R0_ZERO = 1 and wb_rd = 0.
  - Combinational read with bypass: when wb_we = 1 and wb_rd equals the source register, the read returns wb_data in the same cycle.
- Scoreboard, one bit per register:
  - Set on an output fire (out_valid & out_ready) whose bundle has sel_wb = 1.
  - Cleared on wb_we for wb_rd.
  - If set and clear hit the same register in the same cycle, set wins.
- Hazard: a used source is blocked if either holds:
  - its scoreboard bit is 1 and the register is not being written back this cycle;
  - out_valid = 1, the output bundle has sel_wb = 1, and its rd matches the source.
  - R0 is never blocked when R0_ZERO = 1.
- in_ready = !hazard & (!out_valid | out_ready) & !flush. While in_valid = 0, hazard is forced to 0.
- Accept (in_valid & in_ready): the output register loads the decoded bundle and out_valid becomes 1 on the next cycle. Latency is 1 cycle.
- Output fire without accept: out_valid goes to 0.
- While out_valid = 1 and out_ready = 0, all outputs hold stable.
- flush: out_valid goes to 0 next cycle and no scoreboard bit is set for the dropped bundle. Flush takes priority over accept and fire in the same cycle.
- Reset (asynchronous, rst_n = 0):
  - out_valid = 0; all output data and selects = 0.
  - Scoreboard cleared; all registers = 0.
  - A bundle in flight is lost. in_ready = 1 after release.

Test Plan:
- Reset, write r8 = 3 via wb, then instr 0x2113_0000 with r1 = 5, r3 = 7 -> after 1 cycle: out_valid = 1, funtype = 00, funcode = 10, rd_out = 1, opa = 5, opb = 7, sel_wb = 1.
- Bypass: wb_we = 1, wb_rd = 3, wb_data = 0xAA in the same cycle as decoding a reader of r3 -> opb = 0xAA, no stall.
- RAW stall: issue a write to r2, fire it, then a reader of r2 -> in_ready = 0 until wb_we to r2. The reader's opa equals that wb_data one cycle after write-back.
- Backpressure: out_ready = 0 for 3 cycles -> outputs stable, in_ready = 0, out_valid held at 1.
- Flush with a bundle writing r4 in the output stage -> out_valid = 0 next cycle, r4 not busy, and a following reader of r4 is accepted immediately.
- Assert rst_n mid-stall -> out_valid = 0, scoreboard clear, r1 reads 0 afterwards.
